// File: rtl/spi_flash_rd_seq_pkg.sv
// Shared types and constants for the SPI flash read sequencer and its engine bus master.
package spi_flash_rd_seq_pkg;

    localparam logic       CTRL_REG        = 1'b0;
    localparam logic       DATA_REG        = 1'b1;
    localparam logic [7:0] CMD_READ_DFLT   = 8'h03;
    localparam logic [7:0] DUMMY_BYTE_DFLT = 8'hFF;
    localparam int         STATUS_BUSY_BIT = 31;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CS_ON,
        ST_TX,
        ST_TX_POLL,
        ST_RX_TX,
        ST_RX_POLL,
        ST_RX_RD,
        ST_PUSH,
        ST_CS_OFF,
        ST_FIN
    } state_e;

    // One engine register access: which register, byte strobes (0 = read), write data.
    typedef struct packed {
        logic        ctrl;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } bus_req_t;

    function automatic bus_req_t req_cs(input logic cs_on);
        bus_req_t r;
        r.ctrl  = CTRL_REG;
        r.wstrb = 4'b0001;
        r.wdata = {31'h0, cs_on};
        return r;
    endfunction

    function automatic bus_req_t req_tx(input logic [7:0] b);
        bus_req_t r;
        r.ctrl  = DATA_REG;
        r.wstrb = 4'b0001;
        r.wdata = {24'h0, b};
        return r;
    endfunction

    function automatic bus_req_t req_poll();
        bus_req_t r;
        r.ctrl  = CTRL_REG;
        r.wstrb = 4'b0000;
        r.wdata = 32'h0;
        return r;
    endfunction

    function automatic bus_req_t req_rd();
        bus_req_t r;
        r.ctrl  = DATA_REG;
        r.wstrb = 4'b0000;
        r.wdata = 32'h0;
        return r;
    endfunction

endpackage

// File: rtl/spi_flash_rd_seq_bus.sv
// Single-transaction issuer for the SPI engine register port: holds the request until
// spi_ready, captures read data, and leaves one idle cycle after every handshake.
module spi_bus_master
    import spi_flash_rd_seq_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_i,
    input  bus_req_t    req_data_i,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        spi_valid_o,
    output logic        spi_ctrl_o,
    output logic [31:0] spi_wdata_o,
    output logic [3:0]  spi_wstrb_o,
    input  logic [31:0] spi_rdata_i,
    input  logic        spi_ready_i
);

    logic        valid_q, valid_d;
    bus_req_t    req_q, req_d;
    logic        done_q, done_d;
    logic [31:0] rdata_q, rdata_d;

    // done_q is high exactly in the gap cycle; a request raised then starts the next
    // transaction on the following edge, so back-to-back calls see a single idle cycle.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        valid_d = valid_q;
        req_d   = req_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        if (valid_q) begin
            if (spi_ready_i) begin
                valid_d = 1'b0;
                done_d  = 1'b1;
                rdata_d = spi_rdata_i;
            end
        end else if (req_i) begin
            valid_d = 1'b1;
            req_d   = req_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            req_q   <= '0;
            done_q  <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            valid_q <= valid_d;
            req_q   <= req_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    assign done_o      = done_q;
    assign rdata_o     = rdata_q;
    assign spi_valid_o = valid_q;
    assign spi_ctrl_o  = req_q.ctrl;
    assign spi_wdata_o = req_q.wdata;
    assign spi_wstrb_o = req_q.wstrb;

endmodule

// File: rtl/spi_flash_rd_seq.sv
// Flash READ sequencer: CS on, opcode + 24-bit address, LEN dummy-clocked reads streamed
// out with backpressure, CS off, done pulse.
module spi_flash_rd_seq
    import spi_flash_rd_seq_pkg::*;
#(
    parameter logic [7:0] CMD_READ   = CMD_READ_DFLT,
    parameter logic [7:0] DUMMY_BYTE = DUMMY_BYTE_DFLT,
    parameter int         LEN_W      = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             spi_valid,
    output logic             spi_ctrl,
    output logic [31:0]      spi_wdata,
    output logic [3:0]       spi_wstrb,
    input  logic [31:0]      spi_rdata,
    input  logic             spi_ready
);

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [23:0]      addr_q, addr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             busy_q, busy_d;

    logic        bus_req;
    bus_req_t    bus_data;
    logic        bus_done;
    logic [31:0] bus_rdata;
    logic        unused_rdata_bits;

    assign unused_rdata_bits = ^bus_rdata[30:8];

    function automatic logic [7:0] hdr_byte(input logic [1:0] i, input logic [23:0] a);
        case (i)
            2'd0:    return CMD_READ;
            2'd1:    return a[23:16];
            2'd2:    return a[15:8];
            default: return a[7:0];
        endcase
    endfunction

    spi_bus_master u_bus (
        .clk         (clk),
        .resetn      (resetn),
        .req_i       (bus_req),
        .req_data_i  (bus_data),
        .done_o      (bus_done),
        .rdata_o     (bus_rdata),
        .spi_valid_o (spi_valid),
        .spi_ctrl_o  (spi_ctrl),
        .spi_wdata_o (spi_wdata),
        .spi_wstrb_o (spi_wstrb),
        .spi_rdata_i (spi_rdata),
        .spi_ready_i (spi_ready)
    );

    // Each state names the transaction in flight; the next one is requested in the
    // gap cycle where bus_done is high.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        out_data_d = out_data_q;
        busy_d     = busy_q;
        bus_req    = 1'b0;
        bus_data   = req_poll();
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        addr_d   = addr;
                        rem_d    = len;
                        busy_d   = 1'b1;
                        bus_req  = 1'b1;
                        bus_data = req_cs(1'b1);
                        state_d  = ST_CS_ON;
                    end else begin
                        state_d  = ST_FIN;
                    end
                end
            end
            ST_CS_ON: begin
                if (bus_done) begin
                    idx_d    = 2'd0;
                    bus_req  = 1'b1;
                    bus_data = req_tx(hdr_byte(2'd0, addr_q));
                    state_d  = ST_TX;
                end
            end
            ST_TX: begin
                if (bus_done) begin
                    bus_req = 1'b1;
                    state_d = ST_TX_POLL;
                end
            end
            ST_TX_POLL: begin
                if (bus_done) begin
                    bus_req = 1'b1;
                    if (bus_rdata[STATUS_BUSY_BIT]) begin
                        bus_data = req_poll();
                    end else if (idx_q != 2'd3) begin
                        idx_d    = idx_q + 2'd1;
                        bus_data = req_tx(hdr_byte(idx_q + 2'd1, addr_q));
                        state_d  = ST_TX;
                    end else begin
                        bus_data = req_tx(DUMMY_BYTE);
                        state_d  = ST_RX_TX;
                    end
                end
            end
            ST_RX_TX: begin
                if (bus_done) begin
                    bus_req = 1'b1;
                    state_d = ST_RX_POLL;
                end
            end
            ST_RX_POLL: begin
                if (bus_done) begin
                    bus_req = 1'b1;
                    if (bus_rdata[STATUS_BUSY_BIT]) begin
                        bus_data = req_poll();
                    end else begin
                        bus_data = req_rd();
                        state_d  = ST_RX_RD;
                    end
                end
            end
            ST_RX_RD: begin
                if (bus_done) begin
                    out_data_d = bus_rdata[7:0];
                    state_d    = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (out_ready) begin
                    rem_d   = rem_q - LEN_W'(1);
                    bus_req = 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        bus_data = req_cs(1'b0);
                        state_d  = ST_CS_OFF;
                    end else begin
                        bus_data = req_tx(DUMMY_BYTE);
                        state_d  = ST_RX_TX;
                    end
                end
            end
            ST_CS_OFF: begin
                if (bus_done) state_d = ST_FIN;
            end
            ST_FIN: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            idx_q      <= 2'd0;
            addr_q     <= 24'h0;
            rem_q      <= '0;
            out_data_q <= 8'h0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            out_data_q <= out_data_d;
            busy_q     <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign done      = (state_q == ST_FIN);
    assign out_valid = (state_q == ST_PUSH);
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// Directed bench for spi_flash_rd_seq with a behavioural SPI engine and flash model.
module tb_spi_flash_rd_seq;

    typedef enum int {K_NONE, K_CSON, K_CSOFF, K_TX, K_POLL, K_RD} kind_e;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [23:0] addr = 24'h0;
    logic [15:0] len = 16'h0;
    logic        out_ready = 1'b1;
    logic        busy, done, out_valid;
    logic [7:0]  out_data;
    logic        spi_valid, spi_ctrl;
    logic [31:0] spi_wdata;
    logic [3:0]  spi_wstrb;
    logic [31:0] spi_rdata = 32'h0;
    logic        spi_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    // Engine / flash model configuration and observation state.
    logic [7:0] flash_mem [8];
    int    xfer_len = 1;
    int    resp_lat = 0;
    bit    dup_en = 1'b0;
    int    xfer_cnt = 0;
    logic [7:0] pending_rx = 8'h00;
    logic [7:0] rx_latch = 8'h00;
    int    rx_idx = 0;
    int    tx_in_cs = 0;
    bit    dup_flag = 1'b0;
    int    wait_cnt = 0;
    bit    prev_hs = 1'b0;
    bit    prev_valid = 1'b0;
    int    idle_run = 0;
    bit    seen_hs = 1'b0;
    kind_e last_kind = K_NONE;
    logic [36:0] held_req = '0;
    bit    cs_low = 1'b0;
    int    accept_cnt = 0, cs_on_cnt = 0, cs_off_cnt = 0, busy_poll_cnt = 0;
    int    gap_err = 0, drop_err = 0, hold_err = 0, cs_err = 0, rd_early = 0;
    int    busy_tx_err = 0, stall_tx_err = 0, bad_req = 0;
    logic [7:0] mosi_q [$];

    logic [7:0] out_q [$];
    int    done_cnt = 0;
    int    ostab_err = 0;
    bit    prev_ov = 1'b0, prev_acc = 1'b0;
    logic [7:0] prev_od = 8'h00;

    always #5 clk = ~clk;

    spi_flash_rd_seq dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .addr      (addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .spi_valid (spi_valid),
        .spi_ctrl  (spi_ctrl),
        .spi_wdata (spi_wdata),
        .spi_wstrb (spi_wstrb),
        .spi_rdata (spi_rdata),
        .spi_ready (spi_ready)
    );

    // Engine model: acts mid-cycle so its ready/rdata are stable at the DUT's edge.
    always @(negedge clk or negedge resetn) begin
        if (!resetn) begin
            spi_ready = 1'b0;
            spi_rdata = 32'h0;
            xfer_cnt  = 0;
            rx_latch  = 8'h00;
            dup_flag  = 1'b0;
            wait_cnt  = 0;
            prev_hs   = 1'b0;
            prev_valid = 1'b0;
            idle_run  = 0;
            seen_hs   = 1'b0;
            last_kind = K_NONE;
            cs_low    = 1'b0;
        end else begin
            if (xfer_cnt != 0) begin
                xfer_cnt--;
                if (xfer_cnt == 0) rx_latch = pending_rx;
            end
            if (prev_hs && spi_valid) gap_err++;
            if (prev_valid && !spi_valid && !prev_hs) drop_err++;
            if (spi_valid && !prev_valid && seen_hs && last_kind != K_RD &&
                last_kind != K_CSOFF && idle_run != 1) gap_err++;
            if (spi_valid && prev_valid && !prev_hs && {spi_ctrl, spi_wstrb, spi_wdata} !== held_req)
                hold_err++;
            if (spi_valid && !(prev_valid && !prev_hs)) held_req = {spi_ctrl, spi_wstrb, spi_wdata};
            idle_run = spi_valid ? 0 : idle_run + 1;
            if (spi_ready) begin
                if (dup_en && !dup_flag) dup_flag = 1'b1;
                else begin
                    spi_ready = 1'b0;
                    dup_flag  = 1'b0;
                end
            end else if (spi_valid) begin
                if (wait_cnt < resp_lat) wait_cnt++;
                else begin
                    wait_cnt = 0;
                    accept_cnt++;
                    seen_hs = 1'b1;
                    spi_rdata = 32'h0;
                    case ({spi_ctrl, spi_wstrb})
                        5'b0_0001: begin
                            cs_low = spi_wdata[0];
                            if (spi_wdata[0]) begin
                                cs_on_cnt++;
                                tx_in_cs = 0;
                                rx_idx = 0;
                                last_kind = K_CSON;
                            end else begin
                                cs_off_cnt++;
                                last_kind = K_CSOFF;
                            end
                        end
                        5'b1_0001: begin
                            if (!cs_low) cs_err++;
                            if (xfer_cnt != 0) busy_tx_err++;
                            if (out_valid) stall_tx_err++;
                            mosi_q.push_back(spi_wdata[7:0]);
                            if (tx_in_cs >= 4) begin
                                pending_rx = flash_mem[rx_idx % 8];
                                rx_idx++;
                            end else pending_rx = 8'h00;
                            tx_in_cs++;
                            xfer_cnt = xfer_len;
                            last_kind = K_TX;
                        end
                        5'b0_0000: begin
                            if (!cs_low) cs_err++;
                            if (xfer_cnt != 0) busy_poll_cnt++;
                            spi_rdata = {xfer_cnt != 0, 23'h0, rx_latch};
                            last_kind = K_POLL;
                        end
                        5'b1_0000: begin
                            if (!cs_low) cs_err++;
                            if (xfer_cnt != 0) rd_early++;
                            spi_rdata = {xfer_cnt != 0, 23'h0, rx_latch};
                            last_kind = K_RD;
                        end
                        default: bad_req++;
                    endcase
                    spi_ready = 1'b1;
                end
            end
            prev_hs    = spi_valid && spi_ready;
            prev_valid = spi_valid;
        end
    end

    // Output-stream collector.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (out_valid && out_ready) out_q.push_back(out_data);
        if (out_valid && prev_ov && !prev_acc && out_data !== prev_od) ostab_err++;
        prev_ov  = out_valid;
        prev_acc = out_valid && out_ready;
        prev_od  = out_data;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mosi_pack(input int from, input int n);
        logic [63:0] r = 64'h0;
        for (int i = 0; i < n; i++)
            r = {r[55:0], (from + i < mosi_q.size()) ? mosi_q[from + i] : 8'hEE};
        return r;
    endfunction

    function automatic logic [63:0] out_pack(input int from, input int n);
        logic [63:0] r = 64'h0;
        for (int i = 0; i < n; i++)
            r = {r[55:0], (from + i < out_q.size()) ? out_q[from + i] : 8'hEE};
        return r;
    endfunction

    task automatic pulse_start(input logic [23:0] a, input logic [15:0] l);
        @(posedge clk); #1;
        addr  = a;
        len   = l;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, done_cnt < target, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_protocol(input string tag);
        check({tag, "_gap"}, gap_err, 0);
        check({tag, "_hold"}, hold_err + drop_err, 0);
        check({tag, "_cs"}, cs_err + bad_req + busy_tx_err, 0);
    endtask

    initial begin : stim
        int m0, o0, d0, a0, c0, f0, p0, n, se;
        logic [7:0] held;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_outputs", {busy, done, out_valid, out_data, spi_valid, spi_ctrl, spi_wstrb}, 0);
        check("rst_wdata", spi_wdata, 0);
        @(posedge clk); #1 resetn = 1'b1;

        // 1: two-byte read at 0x123456.
        flash_mem[0] = 8'hA5;
        flash_mem[1] = 8'h3C;
        m0 = mosi_q.size(); o0 = out_q.size(); d0 = done_cnt; c0 = cs_on_cnt; f0 = cs_off_cnt;
        pulse_start(24'h123456, 16'd2);
        wait_done(d0 + 1, 2000, "t1");
        check("t1_mosi_cnt", mosi_q.size() - m0, 6);
        check("t1_mosi", mosi_pack(m0, 6), 64'h0000_0312_3456_FFFF);
        check("t1_out", out_pack(o0, 2), 64'hA53C);
        check("t1_out_cnt", out_q.size() - o0, 2);
        check("t1_done_once", done_cnt - d0, 1);
        check("t1_idle", {busy, cs_low}, 2'b00);
        check("t1_cs_cycles", {cs_on_cnt - c0, cs_off_cnt - f0}, {32'd1, 32'd1});
        check_protocol("t1");

        // 2: zero length -> done next cycle, no bus traffic.
        a0 = accept_cnt; d0 = done_cnt;
        pulse_start(24'h777777, 16'd0);
        @(negedge clk);
        check("t2_done_pulse", {done, busy}, 2'b10);
        @(negedge clk);
        check("t2_done_single", done, 1'b0);
        repeat (10) @(negedge clk);
        check("t2_no_bus", accept_cnt - a0, 0);
        check("t2_done_cnt", done_cnt - d0, 1);

        // 3: three bytes with a 50-cycle consumer stall on the first.
        flash_mem[0] = 8'h11;
        flash_mem[1] = 8'h22;
        flash_mem[2] = 8'h33;
        out_ready = 1'b0;
        o0 = out_q.size(); d0 = done_cnt;
        pulse_start(24'h000100, 16'd3);
        n = 0;
        while (!out_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t3_first_valid", out_valid, 1'b1);
        held = out_data;
        a0 = accept_cnt;
        se = 0;
        repeat (50) begin
            @(negedge clk);
            if (!out_valid || out_data !== held) se++;
        end
        check("t3_stall_stable", se, 0);
        check("t3_stall_no_bus", accept_cnt - a0, 0);
        check("t3_held_byte", held, 8'h11);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done(d0 + 1, 2000, "t3");
        check("t3_out", out_pack(o0, 3), 64'h112233);
        check("t3_out_cnt", out_q.size() - o0, 3);
        check("t3_no_tx_while_valid", stall_tx_err + ostab_err, 0);

        // 4: slow engine, delayed ready, duplicate ready in the gap.
        xfer_len = 40; resp_lat = 2; dup_en = 1'b1;
        flash_mem[0] = 8'h5A;
        m0 = mosi_q.size(); o0 = out_q.size(); d0 = done_cnt; p0 = busy_poll_cnt;
        pulse_start(24'hABCDEF, 16'd1);
        wait_done(d0 + 1, 5000, "t4");
        check("t4_mosi", mosi_pack(m0, 5), 64'h03AB_CDEF_FF);
        check("t4_out", out_pack(o0, 1), 64'h5A);
        check("t4_busy_polls_seen", (busy_poll_cnt - p0) > 4, 1'b1);
        check("t4_rd_early", rd_early, 0);
        check_protocol("t4");
        xfer_len = 1; resp_lat = 0; dup_en = 1'b0;

        // 5: start while busy is ignored.
        flash_mem[0] = 8'h77;
        m0 = mosi_q.size(); o0 = out_q.size(); d0 = done_cnt;
        pulse_start(24'h0A0B0C, 16'd1);
        repeat (4) @(posedge clk);
        #1;
        addr = 24'hFFFFFF; len = 16'd5; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("t5_busy_at_restart", busy, 1'b1);
        wait_done(d0 + 1, 2000, "t5");
        repeat (20) @(negedge clk);
        check("t5_single_done", done_cnt - d0, 1);
        check("t5_mosi", mosi_pack(m0, 5), 64'h030A_0B0C_FF);
        check("t5_mosi_cnt", mosi_q.size() - m0, 5);
        check("t5_out", {out_q.size() - o0, out_pack(o0, 1)}, {32'd1, 64'h77});
        check("t5_busy_low", busy, 1'b0);

        // 6: async reset after the second byte, then a clean sequence.
        for (int i = 0; i < 4; i++) flash_mem[i] = 8'(i + 1);
        o0 = out_q.size();
        pulse_start(24'h000200, 16'd4);
        n = 0;
        while (out_q.size() - o0 < 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t6_two_bytes", out_pack(o0, 2), 64'h0102);
        @(posedge clk); #3 resetn = 1'b0;
        #1;
        check("t6_rst_outputs", {busy, done, out_valid, out_data, spi_valid, spi_ctrl, spi_wstrb}, 0);
        check("t6_rst_wdata", spi_wdata, 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        flash_mem[0] = 8'hC3;
        m0 = mosi_q.size(); o0 = out_q.size(); d0 = done_cnt; c0 = cs_on_cnt; f0 = cs_off_cnt;
        pulse_start(24'h000010, 16'd1);
        wait_done(d0 + 1, 2000, "t6");
        check("t6_mosi", mosi_pack(m0, 5), 64'h0300_0010_FF);
        check("t6_out", {out_q.size() - o0, out_pack(o0, 1)}, {32'd1, 64'hC3});
        check("t6_cs_cycles", {cs_on_cnt - c0, cs_off_cnt - f0}, {32'd1, 32'd1});
        check_protocol("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
